// File: rtl/game_pkg.sv
// Shared widths and the enemy wave state encoding for the game-state controller.
// Pure declarations: no logic, no latency, no flow control.
package game_pkg;
    localparam int LEVEL_W     = 4;
    localparam int ENEMY_CNT_W = 6;
    localparam int SLOT_W      = 3;
    localparam int MAX_LEVEL   = 10;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT,
        DONE
    } wave_state_t;
endpackage

// File: rtl/first_free_slot.sv
// Lowest-zero priority encoder over the enemy slot occupancy mask.
// Purely combinational, 0 cycles; no flow control.
module first_free_slot
    import game_pkg::*;
#(
    parameter int MAX_ACTIVE = 4
) (
    input  logic [MAX_ACTIVE-1:0] mask,
    output logic [SLOT_W-1:0]     slot,
    output logic                  found
);

    // Scan high to low so the last hit written is the lowest free index.
    always_comb begin
        slot  = '0;
        found = 1'b0;
        for (int i = MAX_ACTIVE - 1; i >= 0; i--) begin
            if (!mask[i]) begin
                slot  = SLOT_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enemy_wave_ctrl.sv
// Per-level enemy spawn pacing and live-slot tracking; load and kill reach outputs in 1 cycle.
// Spawn requests hold slot/point until ready; valid drops only while frozen (not playing or reloading).
module enemy_wave_ctrl
    import game_pkg::*;
#(
    parameter int MAX_ACTIVE    = 4,
    parameter int NUM_SPAWN_PTS = 3,
    parameter int BASE_ENEMIES  = 4,
    parameter int STEP_ENEMIES  = 2,
    parameter int SPAWN_BASE    = 50_000_000,
    parameter int SPAWN_STEP    = 4_000_000,
    parameter int SPAWN_MIN     = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   reset_game_i,
    input  logic                   is_playing_i,
    input  logic [LEVEL_W-1:0]     level_i,
    input  logic                   kill_valid_i,
    input  logic [SLOT_W-1:0]      kill_slot_i,
    input  logic                   spawn_ready_i,
    output logic                   spawn_valid_o,
    output logic [SLOT_W-1:0]      spawn_slot_o,
    output logic [1:0]             spawn_point_o,
    output logic [7:0]             active_mask_o,
    output logic [ENEMY_CNT_W-1:0] enemy_left_o
);

    wave_state_t            state;
    logic [7:0]             active_mask;
    logic [ENEMY_CNT_W-1:0] to_spawn;
    logic [CNT_W-1:0]       timer;
    logic [CNT_W-1:0]       interval;

    logic [LEVEL_W-1:0]     lvl_m1;
    logic [31:0]            quota_full;
    logic [ENEMY_CNT_W-1:0] quota;
    logic [39:0]            step_total;
    logic [CNT_W-1:0]       interval_nxt;
    logic [SLOT_W-1:0]      free_slot;
    logic                   free_found;
    logic                   kill_hit;

    // Level 0 is treated as level 1.
    assign lvl_m1     = (level_i == '0) ? '0 : level_i - LEVEL_W'(1);
    assign quota_full = 32'(BASE_ENEMIES) + 32'(STEP_ENEMIES) * 32'(lvl_m1);
    assign quota      = (quota_full > 32'd63) ? 6'd63 : quota_full[ENEMY_CNT_W-1:0];

    // Guarded subtraction: fall to the floor before the difference can wrap.
    assign step_total   = 40'(SPAWN_STEP) * 40'(lvl_m1);
    assign interval_nxt = (step_total + 40'(SPAWN_MIN) >= 40'(SPAWN_BASE))
                        ? CNT_W'(SPAWN_MIN)
                        : CNT_W'(40'(SPAWN_BASE) - step_total);

    // Bits at and above MAX_ACTIVE are never set, so this also rejects out-of-range slots.
    assign kill_hit      = kill_valid_i && active_mask[kill_slot_i];
    assign active_mask_o = active_mask;

    first_free_slot #(
        .MAX_ACTIVE(MAX_ACTIVE)
    ) u_free (
        .mask  (active_mask[MAX_ACTIVE-1:0]),
        .slot  (free_slot),
        .found (free_found)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= IDLE;
            spawn_valid_o <= 1'b0;
            spawn_slot_o  <= '0;
            spawn_point_o <= '0;
            active_mask   <= '0;
            enemy_left_o  <= '0;
            to_spawn      <= '0;
            timer         <= '0;
            interval      <= CNT_W'(SPAWN_BASE);
        end else if (reset_game_i) begin
            state         <= IDLE;
            spawn_valid_o <= 1'b0;
            spawn_point_o <= '0;
            active_mask   <= '0;
            enemy_left_o  <= quota;
            to_spawn      <= quota;
            timer         <= '0;
            interval      <= interval_nxt;
        end else begin
            if (kill_hit) begin
                active_mask[kill_slot_i] <= 1'b0;
                if (enemy_left_o != '0) begin
                    enemy_left_o <= enemy_left_o - ENEMY_CNT_W'(1);
                end
            end

            if (!is_playing_i) begin
                spawn_valid_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (to_spawn != '0 && free_found) begin
                            state         <= REQUEST;
                            spawn_valid_o <= 1'b1;
                            spawn_slot_o  <= free_slot;
                        end
                    end
                    REQUEST: begin
                        if (spawn_valid_o && spawn_ready_i) begin
                            active_mask[spawn_slot_o] <= 1'b1;
                            to_spawn      <= to_spawn - ENEMY_CNT_W'(1);
                            spawn_point_o <= (spawn_point_o == 2'(NUM_SPAWN_PTS - 1))
                                           ? 2'd0 : spawn_point_o + 2'd1;
                            timer         <= '0;
                            spawn_valid_o <= 1'b0;
                            state         <= (to_spawn > ENEMY_CNT_W'(1)) ? WAIT : DONE;
                        end else begin
                            // Re-raise after a freeze; slot stays as chosen.
                            spawn_valid_o <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (timer == interval - CNT_W'(1)) begin
                            if (free_found) begin
                                state         <= REQUEST;
                                spawn_valid_o <= 1'b1;
                                spawn_slot_o  <= free_slot;
                            end
                        end else begin
                            timer <= timer + CNT_W'(1);
                        end
                    end
                    default: begin
                        spawn_valid_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_enemy_wave_ctrl.sv
// Directed bench for enemy_wave_ctrl with a short spawn interval (20 cycles, step 2, floor 8).
module tb_enemy_wave_ctrl;
    import game_pkg::*;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       reset_game_i;
    logic       is_playing_i;
    logic [3:0] level_i;
    logic       kill_valid_i;
    logic [2:0] kill_slot_i;
    logic       spawn_ready_i;
    logic       spawn_valid_o;
    logic [2:0] spawn_slot_o;
    logic [1:0] spawn_point_o;
    logic [7:0] active_mask_o;
    logic [5:0] enemy_left_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    enemy_wave_ctrl #(
        .MAX_ACTIVE(4), .NUM_SPAWN_PTS(3), .BASE_ENEMIES(4), .STEP_ENEMIES(2),
        .SPAWN_BASE(20), .SPAWN_STEP(2), .SPAWN_MIN(8), .CNT_W(26)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .reset_game_i(reset_game_i),
        .is_playing_i(is_playing_i), .level_i(level_i),
        .kill_valid_i(kill_valid_i), .kill_slot_i(kill_slot_i),
        .spawn_ready_i(spawn_ready_i), .spawn_valid_o(spawn_valid_o),
        .spawn_slot_o(spawn_slot_o), .spawn_point_o(spawn_point_o),
        .active_mask_o(active_mask_o), .enemy_left_o(enemy_left_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic test_reset;
        reset_i = 1'b1; reset_game_i = 1'b0; is_playing_i = 1'b0; level_i = 4'd1;
        kill_valid_i = 1'b0; kill_slot_i = 3'd0; spawn_ready_i = 1'b0;
        #12;
        n_cmp++; if (spawn_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0h want 0", spawn_valid_o); end
        n_cmp++; if (spawn_slot_o !== 3'd0) begin n_bad++; $display("FAIL reset_slot: got %0h want 0", spawn_slot_o); end
        n_cmp++; if (spawn_point_o !== 2'd0) begin n_bad++; $display("FAIL reset_point: got %0h want 0", spawn_point_o); end
        n_cmp++; if (active_mask_o !== 8'h00) begin n_bad++; $display("FAIL reset_mask: got %0h want 0", active_mask_o); end
        n_cmp++; if (enemy_left_o !== 6'd0) begin n_bad++; $display("FAIL reset_left: got %0d want 0", enemy_left_o); end
        @(negedge clk_i);
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_load;
        reset_game_i = 1'b1; level_i = 4'd1;
        tick();
        reset_game_i = 1'b0;
        n_cmp++; if (enemy_left_o !== 6'd4) begin n_bad++; $display("FAIL load_left: got %0d want 4", enemy_left_o); end
        n_cmp++; if (active_mask_o !== 8'h00) begin n_bad++; $display("FAIL load_mask: got %0h want 0", active_mask_o); end
        n_cmp++; if (spawn_valid_o !== 1'b0) begin n_bad++; $display("FAIL load_valid: got %0h want 0", spawn_valid_o); end
    endtask

    task automatic test_spawn_pacing;
        int n = 0;
        int t [4] = '{0, 0, 0, 0};
        int sl [4] = '{0, 0, 0, 0};
        int pt [4] = '{0, 0, 0, 0};
        int exp_pt [4] = '{0, 1, 2, 0};
        bit left_bad = 1'b0;
        bit extra = 1'b0;
        is_playing_i = 1'b1; spawn_ready_i = 1'b1;
        for (int i = 0; i < 120 && n < 4; i++) begin
            tick();
            if (enemy_left_o !== 6'd4) left_bad = 1'b1;
            if (spawn_valid_o === 1'b1) begin
                t[n] = cyc; sl[n] = int'(spawn_slot_o); pt[n] = int'(spawn_point_o); n++;
            end
        end
        n_cmp++; if (n != 4) begin n_bad++; $display("FAIL pace_count: got %0d want 4", n); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (sl[k] != k) begin n_bad++; $display("FAIL pace_slot%0d: got %0d want %0d", k, sl[k], k); end
            n_cmp++; if (pt[k] != exp_pt[k]) begin n_bad++; $display("FAIL pace_point%0d: got %0d want %0d", k, pt[k], exp_pt[k]); end
        end
        for (int k = 1; k < 4; k++) begin
            n_cmp++; if (t[k] - t[k-1] != 21) begin n_bad++; $display("FAIL pace_gap%0d: got %0d want 21", k, t[k] - t[k-1]); end
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (enemy_left_o !== 6'd4) left_bad = 1'b1;
            if (spawn_valid_o !== 1'b0) extra = 1'b1;
        end
        n_cmp++; if (left_bad) begin n_bad++; $display("FAIL pace_left: got changes want steady 4"); end
        n_cmp++; if (extra) begin n_bad++; $display("FAIL pace_extra: got valid after quota want none"); end
        n_cmp++; if (dut.state !== DONE) begin n_bad++; $display("FAIL pace_state: got %0d want %0d", dut.state, DONE); end
        n_cmp++; if (active_mask_o !== 8'h0F) begin n_bad++; $display("FAIL pace_mask: got %0h want 0f", active_mask_o); end
    endtask

    task automatic test_kill_countdown;
        int ks [6] = '{5, 0, 1, 2, 3, 0};
        int el [6] = '{4, 3, 2, 1, 0, 0};
        int em [6] = '{15, 14, 12, 8, 0, 0};
        for (int i = 0; i < 6; i++) begin
            kill_valid_i = 1'b1; kill_slot_i = 3'(ks[i]);
            tick();
            n_cmp++; if (int'(enemy_left_o) != el[i]) begin n_bad++; $display("FAIL kill_left%0d: got %0d want %0d", i, enemy_left_o, el[i]); end
            n_cmp++; if (int'(active_mask_o) != em[i]) begin n_bad++; $display("FAIL kill_mask%0d: got %0h want %0h", i, active_mask_o, em[i]); end
        end
        kill_valid_i = 1'b0;
    endtask

    task automatic test_slot_limit;
        int n = 0;
        reset_game_i = 1'b1; level_i = 4'd2;
        tick();
        reset_game_i = 1'b0;
        n_cmp++; if (enemy_left_o !== 6'd6) begin n_bad++; $display("FAIL lim_left: got %0d want 6", enemy_left_o); end
        for (int i = 0; i < 100; i++) begin
            tick();
            if (spawn_valid_o === 1'b1) n++;
        end
        n_cmp++; if (n != 4) begin n_bad++; $display("FAIL lim_count: got %0d want 4", n); end
        n_cmp++; if (active_mask_o !== 8'h0F) begin n_bad++; $display("FAIL lim_mask: got %0h want 0f", active_mask_o); end
        n_cmp++; if (spawn_valid_o !== 1'b0) begin n_bad++; $display("FAIL lim_valid: got %0h want 0", spawn_valid_o); end
        kill_valid_i = 1'b1; kill_slot_i = 3'd2;
        tick();
        kill_valid_i = 1'b0;
        n_cmp++; if (active_mask_o !== 8'h0B) begin n_bad++; $display("FAIL lim_kmask: got %0h want 0b", active_mask_o); end
        n_cmp++; if (enemy_left_o !== 6'd5) begin n_bad++; $display("FAIL lim_kleft: got %0d want 5", enemy_left_o); end
        n_cmp++; if (spawn_valid_o !== 1'b0) begin n_bad++; $display("FAIL lim_kvalid: got %0h want 0", spawn_valid_o); end
        tick();
        n_cmp++; if (spawn_valid_o !== 1'b1) begin n_bad++; $display("FAIL lim_rvalid: got %0h want 1", spawn_valid_o); end
        n_cmp++; if (spawn_slot_o !== 3'd2) begin n_bad++; $display("FAIL lim_rslot: got %0d want 2", spawn_slot_o); end
        n_cmp++; if (spawn_point_o !== 2'd1) begin n_bad++; $display("FAIL lim_rpoint: got %0d want 1", spawn_point_o); end
        tick();
        n_cmp++; if (active_mask_o !== 8'h0F) begin n_bad++; $display("FAIL lim_amask: got %0h want 0f", active_mask_o); end
        n_cmp++; if (enemy_left_o !== 6'd5) begin n_bad++; $display("FAIL lim_aleft: got %0d want 5", enemy_left_o); end
    endtask

    task automatic test_stall_freeze;
        int c1;
        int c2 = -1;
        bit unstable = 1'b0;
        bit leaked = 1'b0;
        spawn_ready_i = 1'b0;
        reset_game_i = 1'b1; level_i = 4'd1;
        tick();
        reset_game_i = 1'b0;
        n_cmp++; if (enemy_left_o !== 6'd4) begin n_bad++; $display("FAIL stall_left: got %0d want 4", enemy_left_o); end
        tick();
        n_cmp++; if (spawn_valid_o !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %0h want 1", spawn_valid_o); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (spawn_valid_o !== 1'b1 || spawn_slot_o !== 3'd0 || spawn_point_o !== 2'd0) unstable = 1'b1;
        end
        n_cmp++; if (unstable) begin n_bad++; $display("FAIL stall_hold: got changing request want valid=1 slot=0 point=0"); end
        is_playing_i = 1'b0;
        tick();
        n_cmp++; if (spawn_valid_o !== 1'b0) begin n_bad++; $display("FAIL freeze_valid: got %0h want 0", spawn_valid_o); end
        is_playing_i = 1'b1;
        tick();
        n_cmp++; if (spawn_valid_o !== 1'b1) begin n_bad++; $display("FAIL resume_valid: got %0h want 1", spawn_valid_o); end
        n_cmp++; if (spawn_slot_o !== 3'd0) begin n_bad++; $display("FAIL resume_slot: got %0d want 0", spawn_slot_o); end
        spawn_ready_i = 1'b1;
        c1 = cyc;
        for (int i = 0; i < 5; i++) tick();
        is_playing_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (spawn_valid_o !== 1'b0) leaked = 1'b1;
        end
        is_playing_i = 1'b1;
        n_cmp++; if (leaked) begin n_bad++; $display("FAIL freeze_wait: got valid while frozen want 0"); end
        for (int i = 0; i < 60 && c2 < 0; i++) begin
            tick();
            if (spawn_valid_o === 1'b1) c2 = cyc;
        end
        n_cmp++; if (c2 - c1 != 27) begin n_bad++; $display("FAIL freeze_gap: got %0d want 27", c2 - c1); end
        n_cmp++; if (spawn_slot_o !== 3'd1) begin n_bad++; $display("FAIL freeze_slot: got %0d want 1", spawn_slot_o); end
        n_cmp++; if (spawn_point_o !== 2'd1) begin n_bad++; $display("FAIL freeze_point: got %0d want 1", spawn_point_o); end
    endtask

    task automatic test_reload_in_request;
        bit seen = 1'b0;
        int h1;
        int h2 = -1;
        tick();
        spawn_ready_i = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (spawn_valid_o === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL rl_req: got no request want valid"); end
        n_cmp++; if (active_mask_o !== 8'h03) begin n_bad++; $display("FAIL rl_premask: got %0h want 03", active_mask_o); end
        reset_game_i = 1'b1; level_i = 4'd10; kill_valid_i = 1'b1; kill_slot_i = 3'd0;
        tick();
        reset_game_i = 1'b0; kill_valid_i = 1'b0;
        n_cmp++; if (spawn_valid_o !== 1'b0) begin n_bad++; $display("FAIL rl_valid: got %0h want 0", spawn_valid_o); end
        n_cmp++; if (active_mask_o !== 8'h00) begin n_bad++; $display("FAIL rl_mask: got %0h want 0", active_mask_o); end
        n_cmp++; if (enemy_left_o !== 6'd22) begin n_bad++; $display("FAIL rl_left: got %0d want 22", enemy_left_o); end
        spawn_ready_i = 1'b1;
        tick();
        h1 = cyc;
        n_cmp++; if (spawn_valid_o !== 1'b1 || spawn_slot_o !== 3'd0) begin n_bad++; $display("FAIL rl_first: got valid=%0h slot=%0d want valid=1 slot=0", spawn_valid_o, spawn_slot_o); end
        tick();
        for (int i = 0; i < 30 && h2 < 0; i++) begin
            tick();
            if (spawn_valid_o === 1'b1) h2 = cyc;
        end
        n_cmp++; if (h2 - h1 != 9) begin n_bad++; $display("FAIL rl_gap: got %0d want 9", h2 - h1); end
        reset_game_i = 1'b1; level_i = 4'd0;
        tick();
        reset_game_i = 1'b0;
        n_cmp++; if (enemy_left_o !== 6'd4) begin n_bad++; $display("FAIL clamp_left: got %0d want 4", enemy_left_o); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_spawn_pacing();
        test_kill_countdown();
        test_slot_limit();
        test_stall_freeze();
        test_reload_in_request();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/enemy_wave_ctrl.md
Name: enemy_wave_ctrl

Overview:
Producer side of the game-state controller's level interface. Consumes level_i, reset_game_i and is_playing_i, and generates the enemy_left_o count that the game FSM watches for level completion. Paces enemy spawns per level (quota, spawn interval, slot limit) toward the enemy tank engine through a valid/ready spawn handshake. Tracks live enemy slots from kill reports.

Parameters:
MAX_ACTIVE, 4, number of enemy slots on screen at once (1..8)
NUM_SPAWN_PTS, 3, spawn locations, rotated round-robin
BASE_ENEMIES, 4, quota at level 1
STEP_ENEMIES, 2, extra enemies per level above 1
SPAWN_BASE, 50_000_000, spawn interval at level 1, in cycles
SPAWN_STEP, 4_000_000, interval reduction per level above 1
SPAWN_MIN, 10_000_000, interval floor
CNT_W, 26, interval timer width

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
reset_game_i  in  1  level (re)load request from the game FSM
is_playing_i  in  1  gameplay active; low freezes the block
level_i  in  4  current level, 1..10
kill_valid_i  in  1  one-cycle pulse: enemy in kill_slot_i destroyed
kill_slot_i  in  3  slot index of destroyed enemy
spawn_ready_i  in  1  tank engine accepts the spawn
spawn_valid_o  out  1  spawn request
spawn_slot_o  out  3  slot to occupy
spawn_point_o  out  2  spawn location 0..NUM_SPAWN_PTS-1
active_mask_o  out  8  occupied slots; bits at index MAX_ACTIVE and above are always 0
enemy_left_o  out  6  enemies still to be destroyed (unspawned + active)

Behaviour:
- Reset (reset_i): state IDLE, spawn_valid_o=0, spawn_slot_o=0, spawn_point_o=0, active_mask_o=0, enemy_left_o=0, to_spawn=0, timer=0, interval=SPAWN_BASE.
- Load: reset_game_i high is sampled each cycle and has top priority over any kill or accept in the same cycle. On the next edge:
  - Level clamp: lvl = max(level_i,1).
  - Quota: min(63, BASE_ENEMIES + STEP_ENEMIES*(lvl-1)), loaded into both to_spawn and enemy_left_o.
  - Interval: max(SPAWN_MIN, SPAWN_BASE - SPAWN_STEP*(lvl-1)), computed with signed or guarded subtraction so there is no wrap; loaded into the interval register.
  - Also: active_mask_o=0, spawn_point_o=0, timer=0, state IDLE, spawn_valid_o=0.
- Freeze: while is_playing_i=0 or reset_game_i=1, spawn_valid_o=0, the timer holds and the state holds. Withdrawing valid without ready is permitted only in this case.
- States:
  - IDLE: when playing and to_spawn>0 and a free slot exists -> REQUEST. The first spawn of a level is therefore issued with no interval wait.
  - REQUEST: spawn_valid_o=1 (registered). spawn_slot_o = lowest free slot. Slot and point stay stable while valid && !ready. On valid && ready: set the active_mask bit, to_spawn-1, spawn_point_o+1 mod NUM_SPAWN_PTS, timer=0, then go to WAIT if to_spawn>1 and to DONE otherwise.
  - WAIT: timer increments, saturating at interval-1. When timer==interval-1 and a free slot exists -> REQUEST. If no slot is free, wait there until a kill frees one, then request on the next cycle.
  - DONE: no further requests. Only kills are processed.
- Kill: kill_valid_i with the active_mask bit set for kill_slot_i clears that bit and decrements enemy_left_o.
  - A kill on an inactive or out-of-range slot is ignored.
  - enemy_left_o never underflows.
  - A kill and a spawn accept in the same cycle both apply; they target different slots by construction.
  - A slot freed by a kill is visible as free in the following cycle.
- enemy_left_o changes only on load or a valid kill, never on a spawn.
- Latency: kill to enemy_left_o update is 1 cycle; load to outputs is 1 cycle.

Decomposition:
- Shared package game_pkg: LEVEL_W=4, ENEMY_CNT_W=6, SLOT_W=3, MAX_LEVEL=10, and the wave state enum (IDLE, REQUEST, WAIT, DONE).
- One sub-module: first_free_slot, a combinational lowest-zero priority encoder over active_mask with a found flag, parameterised by MAX_ACTIVE.

Test Plan:
(Simulation parameters: SPAWN_BASE=20, SPAWN_STEP=2, SPAWN_MIN=8.)
1. reset_game_i pulse, level_i=1 -> next cycle enemy_left_o=4, active_mask_o=0, spawn_valid_o=0.
2. is_playing_i=1, spawn_ready_i=1 -> accepts at t0, t0+21, t0+42, t0+63 (timer counts 20, then 1 cycle REQUEST). Slots 0,1,2,3; points 0,1,2,0; enemy_left_o stays 4; final state DONE.
3. Level 2 (quota 6) with no kills -> after 4 spawns active_mask_o=0x0F and no valid. A kill on slot 2 -> valid with spawn_slot_o=2 one cycle after the mask clears; enemy_left_o goes 6->5.
4. Kill slots 0..3 in successive cycles plus a kill on inactive slot 5 -> enemy_left_o counts down 4,3,2,1,0; the slot-5 kill changes nothing.
5. spawn_ready_i low 5 cycles -> valid, slot and point stay stable. Then drop is_playing_i -> valid 0 and timer frozen; restore it -> request resumes.
6. reset_game_i during REQUEST together with a kill, level_i=10 -> valid low next cycle, mask 0, enemy_left_o=22, interval=max(8,20-18)=8, and the kill is ignored.
